// File: rtl/rename_pkg.sv
// Shared rename types and default sizing.
// Decode, ROB and dispatch import the same register typedefs.
package rename_pkg;

  localparam int ARCH_REGS_D = 32;
  localparam int PHYS_REGS_D = 64;
  localparam int WIDTH_D     = 2;

  localparam int AW_D = $clog2(ARCH_REGS_D);
  localparam int PW_D = $clog2(PHYS_REGS_D);

  typedef logic [AW_D-1:0] areg_t;
  typedef logic [PW_D-1:0] preg_t;

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers.
// Holds speculative head, commit head and tail pointers.
module rename_free_list
  import rename_pkg::*;
#(
  parameter  int ARCH_REGS = ARCH_REGS_D,
  parameter  int PHYS_REGS = PHYS_REGS_D,
  parameter  int WIDTH     = WIDTH_D,
  localparam int PW        = $clog2(PHYS_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW:0]   pop_cnt,
  input  logic          push_valid [WIDTH],
  input  logic [PW-1:0] push_pd    [WIDTH],
  input  logic [PW:0]   commit_cnt,
  input  logic          restore,
  output logic [PW-1:0] pop_pd     [WIDTH],
  output logic [PW:0]   free_count
);

  localparam int CW    = PW + 1;
  localparam int FREE0 = PHYS_REGS - ARCH_REGS;

  logic [PW-1:0] mem [PHYS_REGS];
  logic [PW:0]   head;
  logic [PW:0]   chead;
  logic [PW:0]   tail;
  logic [PW:0]   push_cnt;
  logic [PW-1:0] rd_idx [WIDTH];
  logic [PW-1:0] wr_idx [WIDTH];

  // pushes are compacted so retire lanes land in lane order
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rd_idx[i] = head[PW-1:0] + PW'(i);
      pop_pd[i] = mem[rd_idx[i]];
      wr_idx[i] = tail[PW-1:0] + push_cnt[PW-1:0];
      if (push_valid[i]) push_cnt = push_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHYS_REGS; i++)
        mem[i] <= (i < FREE0) ? PW'(ARCH_REGS + i) : '0;
      head  <= '0;
      chead <= '0;
      tail  <= CW'(FREE0);
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (push_valid[i]) mem[wr_idx[i]] <= push_pd[i];
      chead <= chead + commit_cnt;
      head  <= restore ? chead + commit_cnt
                       : head + pop_cnt;
      tail  <= tail + push_cnt;
    end
  end

  assign free_count = tail - head;

endmodule

// File: rtl/rename_unit.sv
// Multi-lane register rename stage with speculative and
// committed RATs, intra-group bypass and flush recovery.
module rename_unit
  import rename_pkg::*;
#(
  parameter  int ARCH_REGS = ARCH_REGS_D,
  parameter  int PHYS_REGS = PHYS_REGS_D,
  parameter  int WIDTH     = WIDTH_D,
  localparam int AW        = $clog2(ARCH_REGS),
  localparam int PW        = $clog2(PHYS_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid   [WIDTH],
  input  logic [AW-1:0] in_rs1     [WIDTH],
  input  logic [AW-1:0] in_rs2     [WIDTH],
  input  logic [AW-1:0] in_rd      [WIDTH],
  input  logic          in_wen     [WIDTH],
  output logic          in_ready,
  output logic          out_valid  [WIDTH],
  output logic [PW-1:0] out_ps1    [WIDTH],
  output logic [PW-1:0] out_ps2    [WIDTH],
  output logic [PW-1:0] out_pd     [WIDTH],
  output logic [PW-1:0] out_old_pd [WIDTH],
  input  logic          ret_valid  [WIDTH],
  input  logic [AW-1:0] ret_rd     [WIDTH],
  input  logic [PW-1:0] ret_pd     [WIDTH],
  input  logic [PW-1:0] ret_old_pd [WIDTH],
  input  logic          ret_wen    [WIDTH],
  input  logic          flush,
  output logic [PW:0]   free_count
);

  localparam int CW = PW + 1;

  logic [PW-1:0] spec_rat    [ARCH_REGS];
  logic [PW-1:0] com_rat     [ARCH_REGS];
  logic [PW-1:0] com_rat_nxt [ARCH_REGS];

  logic          alloc    [WIDTH];
  logic [PW-1:0] pd       [WIDTH];
  logic [PW-1:0] ps1      [WIDTH];
  logic [PW-1:0] ps2      [WIDTH];
  logic [PW-1:0] old_pd   [WIDTH];
  logic [PW-1:0] pop_pd   [WIDTH];
  logic          ret_push [WIDTH];
  logic [CW-1:0] n_alloc;
  logic [CW-1:0] n_ret;
  logic [CW-1:0] pop_cnt;
  logic          any_valid;
  logic          accept;

  // lane i takes the free-list slot after all earlier allocators
  always_comb begin
    n_alloc   = '0;
    any_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      alloc[i] = in_valid[i] && in_wen[i] && (in_rd[i] != '0);
      any_valid = any_valid || in_valid[i];
      pd[i] = '0;
      for (int k = 0; k < WIDTH; k++)
        if (alloc[i] && n_alloc == CW'(k)) pd[i] = pop_pd[k];
      if (alloc[i]) n_alloc = n_alloc + CW'(1);
    end
  end

  // ascending j so the newest earlier writer wins
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      ps1[i] = (in_rs1[i] == '0) ? '0 : spec_rat[in_rs1[i]];
      ps2[i] = (in_rs2[i] == '0) ? '0 : spec_rat[in_rs2[i]];
      old_pd[i] = alloc[i] ? spec_rat[in_rd[i]] : '0;
      for (int j = 0; j < WIDTH; j++) begin
        if (j < i && alloc[j]) begin
          if (in_rd[j] == in_rs1[i]) ps1[i] = pd[j];
          if (in_rd[j] == in_rs2[i]) ps2[i] = pd[j];
          if (alloc[i] && in_rd[j] == in_rd[i])
            old_pd[i] = pd[j];
        end
      end
    end
  end

  always_comb begin
    com_rat_nxt = com_rat;
    n_ret = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ret_push[i] = ret_valid[i] && ret_wen[i]
                    && (ret_rd[i] != '0);
      if (ret_push[i]) begin
        com_rat_nxt[ret_rd[i]] = ret_pd[i];
        n_ret = n_ret + CW'(1);
      end
    end
  end

  assign in_ready = (free_count >= n_alloc) && !flush;
  assign accept   = in_ready && any_valid;
  assign pop_cnt  = accept ? n_alloc : '0;

  rename_free_list #(
    .ARCH_REGS (ARCH_REGS),
    .PHYS_REGS (PHYS_REGS),
    .WIDTH     (WIDTH)
  ) u_free_list (
    .clk        (clk),
    .rst        (rst),
    .pop_cnt    (pop_cnt),
    .push_valid (ret_push),
    .push_pd    (ret_old_pd),
    .commit_cnt (n_ret),
    .restore    (flush),
    .pop_pd     (pop_pd),
    .free_count (free_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat[i] <= PW'(i);
        com_rat[i]  <= PW'(i);
      end
      for (int i = 0; i < WIDTH; i++) begin
        out_valid[i]  <= 1'b0;
        out_ps1[i]    <= '0;
        out_ps2[i]    <= '0;
        out_pd[i]     <= '0;
        out_old_pd[i] <= '0;
      end
    end else begin
      com_rat <= com_rat_nxt;
      if (flush)
        spec_rat <= com_rat_nxt;
      else if (accept)
        for (int i = 0; i < WIDTH; i++)
          if (alloc[i]) spec_rat[in_rd[i]] <= pd[i];
      for (int i = 0; i < WIDTH; i++) begin
        out_valid[i]  <= accept && in_valid[i];
        out_ps1[i]    <= accept ? ps1[i] : '0;
        out_ps2[i]    <= accept ? ps2[i] : '0;
        out_pd[i]     <= accept ? pd[i] : '0;
        out_old_pd[i] <= accept ? old_pd[i] : '0;
      end
    end
  end

endmodule

// File: tb/tb_rename_unit.sv
// Directed self-checking bench for rename_unit.
// Each task resets, drives one scenario and checks inline.
module tb_rename_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid   [2];
  logic [4:0] in_rs1     [2];
  logic [4:0] in_rs2     [2];
  logic [4:0] in_rd      [2];
  logic       in_wen     [2];
  logic       in_ready;
  logic       out_valid  [2];
  logic [5:0] out_ps1    [2];
  logic [5:0] out_ps2    [2];
  logic [5:0] out_pd     [2];
  logic [5:0] out_old_pd [2];
  logic       ret_valid  [2];
  logic [4:0] ret_rd     [2];
  logic [5:0] ret_pd     [2];
  logic [5:0] ret_old_pd [2];
  logic       ret_wen    [2];
  logic       flush;
  logic [6:0] free_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rename_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .in_wen     (in_wen),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ps1    (out_ps1),
    .out_ps2    (out_ps2),
    .out_pd     (out_pd),
    .out_old_pd (out_old_pd),
    .ret_valid  (ret_valid),
    .ret_rd     (ret_rd),
    .ret_pd     (ret_pd),
    .ret_old_pd (ret_old_pd),
    .ret_wen    (ret_wen),
    .flush      (flush),
    .free_count (free_count)
  );

  task automatic clear_ret();
    for (int l = 0; l < 2; l++) begin
      ret_valid[l] = 1'b0; ret_rd[l] = '0;
      ret_pd[l] = '0; ret_old_pd[l] = '0;
      ret_wen[l] = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    for (int l = 0; l < 2; l++) begin
      in_valid[l] = 1'b0; in_rs1[l] = '0;
      in_rs2[l] = '0; in_rd[l] = '0;
      in_wen[l] = 1'b0;
    end
    clear_ret();
    flush = 1'b0;
  endtask

  task automatic set_lane(input int l, input logic [4:0] rs1,
                          input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wen);
    in_valid[l] = 1'b1; in_rs1[l] = rs1;
    in_rs2[l] = rs2; in_rd[l] = rd; in_wen[l] = wen;
  endtask

  task automatic set_ret(input int l, input logic [4:0] rd,
                         input logic [5:0] pd,
                         input logic [5:0] old_pd);
    ret_valid[l] = 1'b1; ret_rd[l] = rd; ret_pd[l] = pd;
    ret_old_pd[l] = old_pd; ret_wen[l] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (free_count !== 7'd32) begin errors++;
      $display("FAIL reset_free_count: got %0d want 32", free_count); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid[0] !== 1'b0 || out_valid[1] !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %b%b want 00", out_valid[1], out_valid[0]); end
    checks++; if (out_pd[0] !== 6'd0 || out_old_pd[1] !== 6'd0) begin errors++;
      $display("FAIL reset_out_regs: got pd %0d old %0d want 0 0", out_pd[0], out_old_pd[1]); end
  endtask

  task automatic test_basic();
    do_reset();
    set_lane(0, 5'd2, 5'd3, 5'd1, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL basic_ready: got %b want 1", in_ready); end
    step();
    clear_inputs();
    checks++; if (out_valid[0] !== 1'b1 || out_valid[1] !== 1'b0) begin errors++;
      $display("FAIL basic_valid: got %b%b want 01", out_valid[1], out_valid[0]); end
    checks++; if (out_ps1[0] !== 6'd2 || out_ps2[0] !== 6'd3) begin errors++;
      $display("FAIL basic_srcs: got %0d %0d want 2 3", out_ps1[0], out_ps2[0]); end
    checks++; if (out_pd[0] !== 6'd32) begin errors++;
      $display("FAIL basic_pd: got %0d want 32", out_pd[0]); end
    checks++; if (out_old_pd[0] !== 6'd1) begin errors++;
      $display("FAIL basic_old_pd: got %0d want 1", out_old_pd[0]); end
    checks++; if (free_count !== 7'd31) begin errors++;
      $display("FAIL basic_free_count: got %0d want 31", free_count); end
    step();
    checks++; if (out_valid[0] !== 1'b0) begin errors++;
      $display("FAIL basic_idle_valid: got %b want 0", out_valid[0]); end
  endtask

  task automatic test_bypass();
    do_reset();
    set_lane(0, 5'd0, 5'd0, 5'd5, 1'b1);
    set_lane(1, 5'd5, 5'd6, 5'd5, 1'b1);
    step();
    clear_inputs();
    checks++; if (out_pd[0] !== 6'd32 || out_old_pd[0] !== 6'd5) begin errors++;
      $display("FAIL bypass_lane0: got pd %0d old %0d want 32 5", out_pd[0], out_old_pd[0]); end
    checks++; if (out_ps1[1] !== 6'd32 || out_ps2[1] !== 6'd6) begin errors++;
      $display("FAIL bypass_lane1_srcs: got %0d %0d want 32 6", out_ps1[1], out_ps2[1]); end
    checks++; if (out_pd[1] !== 6'd33 || out_old_pd[1] !== 6'd32) begin errors++;
      $display("FAIL bypass_lane1_dst: got pd %0d old %0d want 33 32", out_pd[1], out_old_pd[1]); end
    checks++; if (free_count !== 7'd30) begin errors++;
      $display("FAIL bypass_free_count: got %0d want 30", free_count); end
    set_lane(0, 5'd5, 5'd0, 5'd0, 1'b0);
    step();
    clear_inputs();
    checks++; if (out_ps1[0] !== 6'd33 || out_pd[0] !== 6'd0) begin errors++;
      $display("FAIL bypass_rat5: got ps1 %0d pd %0d want 33 0", out_ps1[0], out_pd[0]); end
  endtask

  task automatic test_x0();
    do_reset();
    set_lane(0, 5'd0, 5'd7, 5'd0, 1'b1);
    set_lane(1, 5'd0, 5'd0, 5'd3, 1'b0);
    step();
    clear_inputs();
    checks++; if (out_pd[0] !== 6'd0 || out_old_pd[0] !== 6'd0) begin errors++;
      $display("FAIL x0_dst: got pd %0d old %0d want 0 0", out_pd[0], out_old_pd[0]); end
    checks++; if (out_ps1[0] !== 6'd0 || out_ps2[0] !== 6'd7) begin errors++;
      $display("FAIL x0_srcs: got %0d %0d want 0 7", out_ps1[0], out_ps2[0]); end
    checks++; if (out_valid[1] !== 1'b1 || out_pd[1] !== 6'd0) begin errors++;
      $display("FAIL x0_nowen: got v %b pd %0d want 1 0", out_valid[1], out_pd[1]); end
    checks++; if (free_count !== 7'd32) begin errors++;
      $display("FAIL x0_free_count: got %0d want 32", free_count); end
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int g = 0; g < 16; g++) begin
      set_lane(0, 5'd0, 5'd0, 5'd1, 1'b1);
      set_lane(1, 5'd0, 5'd0, 5'd2, 1'b1);
      step();
    end
    clear_inputs();
    checks++; if (out_pd[0] !== 6'd62 || out_pd[1] !== 6'd63) begin errors++;
      $display("FAIL exh_last_pd: got %0d %0d want 62 63", out_pd[0], out_pd[1]); end
    checks++; if (out_old_pd[1] !== 6'd61) begin errors++;
      $display("FAIL exh_last_old: got %0d want 61", out_old_pd[1]); end
    checks++; if (free_count !== 7'd0) begin errors++;
      $display("FAIL exh_empty: got %0d want 0", free_count); end
    set_lane(0, 5'd0, 5'd0, 5'd3, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL exh_stall_ready: got %b want 0", in_ready); end
    step();
    checks++; if (out_valid[0] !== 1'b0 || free_count !== 7'd0) begin errors++;
      $display("FAIL exh_stall_out: got v %b fc %0d want 0 0", out_valid[0], free_count); end
    set_ret(0, 5'd1, 6'd32, 6'd1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL exh_no_bypass: got %b want 0", in_ready); end
    step();
    clear_ret();
    #1;
    checks++; if (free_count !== 7'd1 || in_ready !== 1'b1) begin errors++;
      $display("FAIL exh_freed: got fc %0d rdy %b want 1 1", free_count, in_ready); end
    step();
    clear_inputs();
    checks++; if (out_valid[0] !== 1'b1 || out_pd[0] !== 6'd1) begin errors++;
      $display("FAIL exh_realloc: got v %b pd %0d want 1 1", out_valid[0], out_pd[0]); end
    checks++; if (out_old_pd[0] !== 6'd3 || free_count !== 7'd0) begin errors++;
      $display("FAIL exh_realloc_old: got old %0d fc %0d want 3 0", out_old_pd[0], free_count); end
    set_ret(0, 5'd2, 6'd33, 6'd2);
    step();
    clear_inputs();
    set_lane(0, 5'd0, 5'd0, 5'd4, 1'b1);
    set_lane(1, 5'd0, 5'd0, 5'd5, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL exh_group_split: got %b want 0", in_ready); end
    step();
    checks++; if (out_valid[0] !== 1'b0 || free_count !== 7'd1) begin errors++;
      $display("FAIL exh_group_hold: got v %b fc %0d want 0 1", out_valid[0], free_count); end
    clear_inputs();
    set_lane(0, 5'd0, 5'd0, 5'd4, 1'b1);
    step();
    clear_inputs();
    checks++; if (out_pd[0] !== 6'd2) begin errors++;
      $display("FAIL exh_second_free: got %0d want 2", out_pd[0]); end
  endtask

  task automatic test_flush();
    do_reset();
    set_lane(0, 5'd0, 5'd0, 5'd1, 1'b1);
    set_lane(1, 5'd0, 5'd0, 5'd2, 1'b1);
    step();
    clear_inputs();
    set_lane(0, 5'd0, 5'd0, 5'd3, 1'b1);
    step();
    clear_inputs();
    checks++; if (out_pd[0] !== 6'd34 || free_count !== 7'd29) begin errors++;
      $display("FAIL flush_pre: got pd %0d fc %0d want 34 29", out_pd[0], free_count); end
    flush = 1'b1;
    set_lane(0, 5'd0, 5'd0, 5'd6, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL flush_ready: got %b want 0", in_ready); end
    step();
    clear_inputs();
    checks++; if (out_valid[0] !== 1'b0 || free_count !== 7'd32) begin errors++;
      $display("FAIL flush_state: got v %b fc %0d want 0 32", out_valid[0], free_count); end
    set_lane(0, 5'd1, 5'd3, 5'd4, 1'b1);
    step();
    clear_inputs();
    checks++; if (out_ps1[0] !== 6'd1 || out_ps2[0] !== 6'd3) begin errors++;
      $display("FAIL flush_rat: got %0d %0d want 1 3", out_ps1[0], out_ps2[0]); end
    checks++; if (out_pd[0] !== 6'd32 || out_old_pd[0] !== 6'd4) begin errors++;
      $display("FAIL flush_alloc: got pd %0d old %0d want 32 4", out_pd[0], out_old_pd[0]); end
  endtask

  task automatic test_flush_retire();
    do_reset();
    set_lane(0, 5'd0, 5'd0, 5'd1, 1'b1);
    set_lane(1, 5'd0, 5'd0, 5'd2, 1'b1);
    step();
    clear_inputs();
    flush = 1'b1;
    set_ret(0, 5'd1, 6'd32, 6'd1);
    step();
    clear_inputs();
    checks++; if (free_count !== 7'd32) begin errors++;
      $display("FAIL flret_free_count: got %0d want 32", free_count); end
    set_lane(0, 5'd1, 5'd2, 5'd5, 1'b1);
    set_lane(1, 5'd0, 5'd0, 5'd6, 1'b1);
    step();
    clear_inputs();
    checks++; if (out_ps1[0] !== 6'd32 || out_ps2[0] !== 6'd2) begin errors++;
      $display("FAIL flret_rat: got %0d %0d want 32 2", out_ps1[0], out_ps2[0]); end
    checks++; if (out_pd[0] !== 6'd33 || out_pd[1] !== 6'd34) begin errors++;
      $display("FAIL flret_alloc: got %0d %0d want 33 34", out_pd[0], out_pd[1]); end
    checks++; if (out_old_pd[0] !== 6'd5 || free_count !== 7'd30) begin errors++;
      $display("FAIL flret_old: got old %0d fc %0d want 5 30", out_old_pd[0], free_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_lane(0, 5'd0, 5'd0, 5'd7, 1'b1);
    step();
    checks++; if (out_pd[0] !== 6'd32) begin errors++;
      $display("FAIL b2b_first: got %0d want 32", out_pd[0]); end
    clear_inputs();
    set_lane(0, 5'd7, 5'd0, 5'd7, 1'b1);
    set_ret(0, 5'd7, 6'd32, 6'd7);
    step();
    clear_inputs();
    checks++; if (out_ps1[0] !== 6'd32 || out_pd[0] !== 6'd33) begin errors++;
      $display("FAIL b2b_second: got ps1 %0d pd %0d want 32 33", out_ps1[0], out_pd[0]); end
    checks++; if (out_old_pd[0] !== 6'd32 || free_count !== 7'd31) begin errors++;
      $display("FAIL b2b_old: got old %0d fc %0d want 32 31", out_old_pd[0], free_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_lane(0, 5'd0, 5'd0, 5'd1, 1'b1);
    step();
    clear_inputs();
    checks++; if (free_count !== 7'd31) begin errors++;
      $display("FAIL areset_pre: got %0d want 31", free_count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (free_count !== 7'd32 || out_valid[0] !== 1'b0) begin errors++;
      $display("FAIL areset_clear: got fc %0d v %b want 32 0", free_count, out_valid[0]); end
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_bypass();
    test_x0();
    test_exhaust();
    test_flush();
    test_flush_retire();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
